// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: serializer states,
// register offsets within the window and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_EMPTY   = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Generic synchronous FIFO with show-ahead head; writes land one edge after push.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-driven UART transmitter: TXDATA stores queue bytes, an 8N1 serializer drains them.
// Pop one edge after the first push; full FIFO drops the byte and sets sticky overflow.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'd256,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              overflow_q, overflow_d;

  logic              sel_txdata, sel_status;
  logic              wr_txdata, wr_status;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_dat;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       status;
  logic              unused_wdata;

  assign sel_txdata   = (DataAddr == BASE_ADDR + TXDATA_OFS);
  assign sel_status   = (DataAddr == BASE_ADDR + STATUS_OFS);
  assign hit          = sel_txdata || sel_status;
  assign wr_txdata    = MemWrite && sel_txdata;
  assign wr_status    = MemWrite && sel_status;
  assign unused_wdata = ^WriteData[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_txdata),
    .push_dat (WriteData[7:0]),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign busy = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    status                = '0;
    status[ST_BUSY]       = busy;
    status[ST_FULL]       = fifo_full;
    status[ST_EMPTY]      = fifo_empty;
    status[ST_OVF]        = overflow_q;
    status[ST_CNT_LSB+:4] = 4'(fifo_count);
  end

  assign ReadData = sel_status ? status : 32'd0;

  // A set in the same cycle as a clear must win, so it is applied last.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_status && WriteData[3]) overflow_d = 1'b0;
    if (wr_txdata && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx       = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dat;
          baud_d   = BAUD_MAX;
          state_d  = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_q == '0) begin
          baud_d  = BAUD_MAX;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (baud_q == '0) begin
          baud_d  = BAUD_MAX;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dat;
            baud_d   = BAUD_MAX;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at 4 clocks per bit; a background monitor decodes frames on tx.
module tb_mmio_uart_tx;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;
  logic        tx;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] rx_q[$];
  int         st_q[$];
  logic       sp_q[$];

  mmio_uart_tx #(
    .BASE_ADDR    (32'd256),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAddr  (DataAddr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .hit       (hit),
    .tx        (tx),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output int wcyc);
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAddr  = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    wcyc      = cyc;
    MemWrite  = 1'b0;
    DataAddr  = 32'd0;
    WriteData = 32'd0;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    DataAddr = 32'd260;
    #1;
    chk(tag, ReadData, exp);
    DataAddr = 32'd0;
  endtask

  task automatic wait_frames(input int n, input int max_cyc);
    int k = 0;
    while (rx_q.size() < n && k < max_cyc) begin
      step();
      k++;
    end
    chk("frame_count_reached", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy !== 1'b0 && k < max_cyc) begin
      step();
      k++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic flush();
    rx_q.delete();
    st_q.delete();
    sp_q.delete();
  endtask

  // Frame monitor: start bit seen at frame cycle 0, each bit sampled at its mid-point.
  logic [7:0] mon_b;
  int         mon_s;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset && tx === 1'b0) begin
        mon_s = cyc;
        repeat (2) step();
        for (int i = 0; i < 8; i++) begin
          repeat (4) step();
          mon_b[i] = tx;
        end
        repeat (4) step();
        rx_q.push_back(mon_b);
        st_q.push_back(mon_s);
        sp_q.push_back(tx);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int         wc0, wc1;
    logic [39:0] cap;
    logic [39:0] exp_v;
    logic [9:0]  frame;
    logic [7:0]  ovf_bytes [5];

    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAddr  = 32'd0;
    WriteData = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    read_status("reset_status", 32'h0000_0004);
    @(negedge clk);
    reset = 1'b0;
    step();
    flush();

    // Single byte 0x55 (upper store bits ignored)
    bus_write(32'd256, 32'h0000_0155, wc0);
    chk("single_tx_before_pop", tx, 1);
    chk("single_busy_after_push", busy, 1);
    step();
    cap[0] = tx;
    for (int i = 1; i < 40; i++) begin
      step();
      cap[i] = tx;
    end
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) exp_v[i] = frame[i / 4];
    chk("single_waveform", cap, exp_v);
    chk("single_busy_last_stop_cycle", busy, 1);
    step();
    chk("single_busy_done", busy, 0);
    chk("single_tx_idle", tx, 1);
    if (st_q.size() > 0) chk("single_start_cycle", st_q[0], wc0 + 1);
    else chk("single_start_cycle", 0, 1);

    // Back-to-back stores and STATUS read
    wait_idle(200);
    flush();
    bus_write(32'd256, 32'h0000_00A0, wc0);
    bus_write(32'd256, 32'h0000_00A1, wc1);
    read_status("b2b_status", 32'h0000_0101);
    wait_frames(2, 200);
    if (rx_q.size() >= 2) begin
      chk("b2b_byte0", rx_q[0], 8'hA0);
      chk("b2b_byte1", rx_q[1], 8'hA1);
      chk("b2b_start0", st_q[0], wc0 + 1);
      chk("b2b_gap", st_q[1] - st_q[0], 40);
      chk("b2b_stop", {sp_q[0], sp_q[1]}, 2'b11);
    end
    wait_idle(200);

    // Overflow: six stores, one popped, four queued, one dropped
    flush();
    for (int i = 0; i < 6; i++) bus_write(32'd256, 32'hFFFF_FF10 + i, wc0);
    read_status("ovf_status_set", 32'h0000_040B);
    bus_write(32'd260, 32'd8, wc1);
    read_status("ovf_status_cleared", 32'h0000_0403);
    wait_frames(5, 400);
    ovf_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    for (int i = 0; i < 5; i++) begin
      if (rx_q.size() > i) chk($sformatf("ovf_byte%0d", i), rx_q[i], ovf_bytes[i]);
      if (i > 0 && st_q.size() > i) chk($sformatf("ovf_gap%0d", i), st_q[i] - st_q[i-1], 40);
    end
    wait_idle(200);
    repeat (60) step();
    chk("ovf_exactly_five", rx_q.size(), 5);
    read_status("ovf_status_idle", 32'h0000_0004);

    // Address isolation
    flush();
    DataAddr = 32'd104;
    #1;
    chk("iso_hit", hit, 0);
    chk("iso_rdata", ReadData, 0);
    DataAddr = 32'd256;
    #1;
    chk("txdata_hit", hit, 1);
    chk("txdata_reads_zero", ReadData, 0);
    bus_write(32'd104, 32'd25, wc0);
    chk("iso_busy", busy, 0);
    chk("iso_tx", tx, 1);
    repeat (50) step();
    chk("iso_no_frame", rx_q.size(), 0);
    read_status("iso_status", 32'h0000_0004);

    // Reset during DATA bit 3 of 0xC3 with two more bytes queued
    bus_write(32'd256, 32'h0000_00C3, wc0);
    bus_write(32'd256, 32'h0000_003C, wc1);
    bus_write(32'd256, 32'h0000_005A, wc1);
    repeat (16) step();
    chk("rst_pre_tx_low", tx, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_status("rst_status", 32'h0000_0004);
    repeat (60) step();
    flush();
    repeat (100) step();
    chk("rst_no_more_frames", rx_q.size(), 0);
    chk("rst_tx_idle", tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
